// File: rtl/mem_access_sequencer_if.sv
// mem_access_sequencer_if
//   Data-RAM bus between the load/store sequencer (master) and the RAM (slave).
//   ram_req    master->slave  request, held until ram_ack
//   ram_we     master->slave  1 = write
//   ram_addr   master->slave  word address (low two bits zero)
//   ram_be     master->slave  byte enables, bit i covers bits [8i+7:8i]
//   ram_wdata  master->slave  lane-replicated store data
//   ram_ack    slave->master  transaction completes in the cycle it is high
//   ram_rdata  slave->master  read word, valid with ram_ack
interface mem_access_sequencer_if;
   logic        ram_req;
   logic        ram_we;
   logic [31:0] ram_addr;
   logic [3:0]  ram_be;
   logic [31:0] ram_wdata;
   logic        ram_ack;
   logic [31:0] ram_rdata;

   modport master (
      output ram_req, ram_we, ram_addr, ram_be, ram_wdata,
      input  ram_ack, ram_rdata
   );

   modport slave (
      input  ram_req, ram_we, ram_addr, ram_be, ram_wdata,
      output ram_ack, ram_rdata
   );
endinterface

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer
//   Multi-cycle sequencer between the datapath load/store stage and the data
//   RAM. One RAM transaction per access; generates byte lanes, extracts and
//   extends load data, stalls the datapath until the access completes.
//   Misaligned/illegal accesses and RAM timeouts are reported as pulses.
// Parameters
//   TIMEOUT      ACCESS cycles without ram_ack before abort (1..255)
// Ports
//   clk, reset   clock (rising edge), synchronous active-high reset
//   mem_en       access request, sampled in IDLE only
//   mem_rw       1 = load, 0 = store
//   mem_size     00 byte, 01 half, 10 word, 11 illegal
//   mem_sign     1 = sign-extend load, 0 = zero-extend
//   mem_addr     byte address
//   mem_wdata    store data, right-justified
//   stall        hold datapath (combinational)
//   rdata        extended load data, holds until the next load completes
//   rdata_valid  1-cycle pulse, load completed OK
//   align_err    1-cycle pulse, misaligned/illegal access rejected
//   bus_err      1-cycle pulse, RAM timeout
//   ram_bus      RAM bus (master side)
module mem_access_sequencer #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_en,
   input  logic        mem_rw,
   input  logic [1:0]  mem_size,
   input  logic        mem_sign,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        rdata_valid,
   output logic        align_err,
   output logic        bus_err,
   mem_access_sequencer_if.master ram_bus
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE, S_ERR} state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, wdata_q;
   logic [1:0]  size_q;
   logic        sign_q, rw_q;
   logic [7:0]  tcnt_q;
   logic        load_ok_q, tmo_q;

   logic        aligned, in_access, expired;
   logic [3:0]  be_c;
   logic [31:0] wdata_c, load_ext;
   logic [15:0] lane;

   always_comb begin
      unique case (mem_size)
         2'b00:   aligned = 1'b1;
         2'b01:   aligned = ~mem_addr[0];
         2'b10:   aligned = (mem_addr[1:0] == 2'b00);
         default: aligned = 1'b0;
      endcase
   end

   assign in_access = (state_q == S_ACCESS);
   // Abort on the TIMEOUT-th ACCESS cycle that passes without an ack.
   assign expired   = in_access && !ram_bus.ram_ack && (tcnt_q == 8'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      stall       = 1'b0;
      rdata_valid = 1'b0;
      align_err   = 1'b0;
      bus_err     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            stall = mem_en & aligned;
            if (mem_en) state_d = aligned ? S_ACCESS : S_ERR;
         end
         S_ACCESS: begin
            stall = 1'b1;
            if (ram_bus.ram_ack || expired) state_d = S_DONE;
         end
         S_DONE: begin
            rdata_valid = load_ok_q;
            bus_err     = tmo_q;
            state_d     = S_IDLE;
         end
         S_ERR: begin
            align_err = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Lane generation from the captured access
   always_comb begin
      unique case (size_q)
         2'b00: begin
            be_c    = 4'b0001 << addr_q[1:0];
            wdata_c = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            be_c    = addr_q[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{wdata_q[15:0]}};
         end
         default: begin
            be_c    = 4'b1111;
            wdata_c = wdata_q;
         end
      endcase
   end

   always_comb begin
      ram_bus.ram_req   = in_access;
      ram_bus.ram_we    = in_access & ~rw_q;
      ram_bus.ram_addr  = in_access ? {addr_q[31:2], 2'b00} : '0;
      ram_bus.ram_be    = in_access ? be_c : '0;
      ram_bus.ram_wdata = in_access ? wdata_c : '0;
   end

   // Load extraction: shift the addressed lane down, then extend
   always_comb begin
      lane = 16'(ram_bus.ram_rdata >> {addr_q[1:0], 3'b000});
      unique case (size_q)
         2'b00:   load_ext = {{24{sign_q & lane[7]}}, lane[7:0]};
         2'b01:   load_ext = {{16{sign_q & lane[15]}}, lane};
         default: load_ext = ram_bus.ram_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q    <= '0;
         wdata_q   <= '0;
         size_q    <= '0;
         sign_q    <= 1'b0;
         rw_q      <= 1'b0;
         tcnt_q    <= '0;
         load_ok_q <= 1'b0;
         tmo_q     <= 1'b0;
         rdata     <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (mem_en) begin
                  addr_q    <= mem_addr;
                  wdata_q   <= mem_wdata;
                  size_q    <= mem_size;
                  sign_q    <= mem_sign;
                  rw_q      <= mem_rw;
                  tcnt_q    <= '0;
                  load_ok_q <= 1'b0;
                  tmo_q     <= 1'b0;
               end
            end
            S_ACCESS: begin
               if (ram_bus.ram_ack) begin
                  load_ok_q <= rw_q;
                  if (rw_q) rdata <= load_ext;
               end else if (expired) begin
                  tmo_q <= 1'b1;
                  rdata <= '0;
               end else begin
                  tcnt_q <= tcnt_q + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_sequencer.sv
module tb_mem_access_sequencer;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_en, mem_rw, mem_sign;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata;
   logic        stall, rdata_valid, align_err, bus_err;
   logic [31:0] rdata;

   mem_access_sequencer_if ram_bus ();

   mem_access_sequencer #(.TIMEOUT(TO)) dut (
      .clk         (clk),
      .reset       (reset),
      .mem_en      (mem_en),
      .mem_rw      (mem_rw),
      .mem_size    (mem_size),
      .mem_sign    (mem_sign),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .stall       (stall),
      .rdata       (rdata),
      .rdata_valid (rdata_valid),
      .align_err   (align_err),
      .bus_err     (bus_err),
      .ram_bus     (ram_bus)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] model_rdata = '0;

   // ---------------- reference model ----------------
   function automatic int m_nb(logic [1:0] size);
      case (size)
         2'd0:    return 1;
         2'd1:    return 2;
         2'd2:    return 4;
         default: return 0;
      endcase
   endfunction

   function automatic bit m_misaligned(logic [1:0] size, logic [31:0] addr);
      int nb = m_nb(size);
      if (nb == 0) return 1'b1;
      return (addr % nb) != 0;
   endfunction

   function automatic logic [3:0] m_be(logic [1:0] size, logic [31:0] addr);
      int nb = m_nb(size);
      return 4'(((1 << nb) - 1) << (addr % 4));
   endfunction

   function automatic logic [31:0] m_wdata(logic [1:0] size, logic [31:0] w);
      int nb = m_nb(size);
      if (nb == 1) return (w & 32'hFF) * 32'h01010101;
      if (nb == 2) return (w & 32'hFFFF) * 32'h00010001;
      return w;
   endfunction

   function automatic logic [31:0] m_load(logic [31:0] word, logic [1:0] size,
                                          bit sign, logic [31:0] addr);
      int nb = m_nb(size);
      logic [31:0] mask, v;
      if (nb == 4) return word;
      mask = (32'h1 << (8 * nb)) - 32'h1;
      v    = (word >> (8 * (addr % 4))) & mask;
      if (sign && v[8 * nb - 1]) v = v | ~mask;
      return v;
   endfunction

   // ---------------- one access, observed cycle by cycle ----------------
   task automatic run_access(input bit rw, input logic [1:0] size, input bit sign,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rword, input int ack_at,
                             input bit hold_en, input string tag);
      int stall_n = 0, req_n = 0, valid_n = 0, align_n = 0, bus_n = 0, bus_bad = 0;
      int exp_stall, exp_req, exp_valid, exp_align, exp_bus;
      bit done = 0, mis, idle_bad;
      logic [31:0] got_rdata = '0;

      mis = m_misaligned(size, addr);
      if (mis) begin
         exp_stall = 0; exp_req = 0; exp_valid = 0; exp_align = 1; exp_bus = 0;
      end else if (ack_at >= 0 && ack_at < TO) begin
         exp_req = ack_at + 1; exp_stall = ack_at + 2; exp_valid = rw ? 1 : 0;
         exp_align = 0; exp_bus = 0;
         if (rw) model_rdata = m_load(rword, size, sign, addr);
      end else begin
         exp_req = TO; exp_stall = TO + 1; exp_valid = 0; exp_align = 0; exp_bus = 1;
         model_rdata = '0;
      end

      @(negedge clk);
      mem_en = 1'b1; mem_rw = rw; mem_size = size; mem_sign = sign;
      mem_addr = addr; mem_wdata = wdata;
      ram_bus.ram_ack = 1'b0; ram_bus.ram_rdata = $urandom;
      #1;
      for (int i = 0; i < 40 && !done; i++) begin
         if (stall) stall_n++;
         if (ram_bus.ram_req) begin
            if (ram_bus.ram_addr !== (addr & ~32'h3) || ram_bus.ram_be !== m_be(size, addr) ||
                ram_bus.ram_we !== ~rw || (!rw && ram_bus.ram_wdata !== m_wdata(size, wdata)))
               bus_bad++;
            req_n++;
            if (req_n - 1 == ack_at) begin
               ram_bus.ram_ack = 1'b1;
               ram_bus.ram_rdata = rword;
            end
         end
         if (rdata_valid) begin valid_n++; got_rdata = rdata; end
         if (align_err) align_n++;
         if (bus_err) bus_n++;
         if (i > 0 && !stall && !ram_bus.ram_req) done = 1;
         @(negedge clk);
         ram_bus.ram_ack = 1'b0;
         ram_bus.ram_rdata = $urandom;
         if (!hold_en || done) mem_en = 1'b0;
         #1;
      end

      total++;
      if (!done) begin
         bad++;
         $display("FAIL %s completion got=timeout_after_40 exp=done", tag);
      end
      total++;
      if (stall_n !== exp_stall) begin
         bad++; $display("FAIL %s stall_cycles got=%0d exp=%0d", tag, stall_n, exp_stall);
      end
      total++;
      if (req_n !== exp_req) begin
         bad++; $display("FAIL %s req_cycles got=%0d exp=%0d", tag, req_n, exp_req);
      end
      total++;
      if (bus_bad !== 0) begin
         bad++; $display("FAIL %s bus_fields bad_cycles got=%0d exp=0", tag, bus_bad);
      end
      total++;
      if (valid_n !== exp_valid) begin
         bad++; $display("FAIL %s rdata_valid_pulses got=%0d exp=%0d", tag, valid_n, exp_valid);
      end
      total++;
      if (align_n !== exp_align) begin
         bad++; $display("FAIL %s align_err_pulses got=%0d exp=%0d", tag, align_n, exp_align);
      end
      total++;
      if (bus_n !== exp_bus) begin
         bad++; $display("FAIL %s bus_err_pulses got=%0d exp=%0d", tag, bus_n, exp_bus);
      end
      if (exp_valid == 1) begin
         total++;
         if (got_rdata !== model_rdata) begin
            bad++; $display("FAIL %s load_data got=%h exp=%h", tag, got_rdata, model_rdata);
         end
      end
      total++;
      if (rdata !== model_rdata) begin
         bad++; $display("FAIL %s rdata_hold got=%h exp=%h", tag, rdata, model_rdata);
      end
      // IDLE now, then one more cycle: nothing may start on its own
      idle_bad = stall || ram_bus.ram_req || rdata_valid || align_err || bus_err;
      @(negedge clk); #1;
      idle_bad = idle_bad || ram_bus.ram_req || stall;
      total++;
      if (idle_bad) begin
         bad++; $display("FAIL %s idle_after got=busy exp=quiet", tag);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1; mem_en = 1'b0; mem_rw = 1'b0; mem_size = '0; mem_sign = 1'b0;
      mem_addr = '0; mem_wdata = '0; ram_bus.ram_ack = 1'b0; ram_bus.ram_rdata = '0;
      repeat (3) @(negedge clk);
      #1;
      total++;
      if ({stall, rdata, rdata_valid, align_err, bus_err, ram_bus.ram_req, ram_bus.ram_we,
           ram_bus.ram_addr, ram_bus.ram_be, ram_bus.ram_wdata} !== '0) begin
         bad++;
         $display("FAIL reset_outputs got=req%b stall%b rdata=%h be=%b exp=all_zero",
                  ram_bus.ram_req, stall, rdata, ram_bus.ram_be);
      end
      @(negedge clk);
      reset = 1'b0;
      model_rdata = '0;
   endtask

   task automatic test_idle_ack();
      bit noisy = 0;
      @(negedge clk);
      mem_en = 1'b0;
      for (int i = 0; i < 6; i++) begin
         ram_bus.ram_ack = 1'($urandom); ram_bus.ram_rdata = $urandom;
         #1;
         if (stall || ram_bus.ram_req || rdata_valid || align_err || bus_err ||
             rdata !== model_rdata) noisy = 1;
         @(negedge clk);
      end
      ram_bus.ram_ack = 1'b0;
      total++;
      if (noisy) begin
         bad++; $display("FAIL idle_ack_ignored got=activity exp=none");
      end
   endtask

   task automatic test_directed();
      run_access(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 2, 1'b1, "lw_0x10");
      total++;
      if (rdata !== 32'hDEADBEEF) begin
         bad++; $display("FAIL lw_0x10_value got=%h exp=deadbeef", rdata);
      end
      run_access(1'b1, 2'b00, 1'b1, 32'h13, 32'h0, 32'h80FF1234, 0, 1'b0, "lb_sign");
      total++;
      if (rdata !== 32'hFFFFFF80) begin
         bad++; $display("FAIL lb_sign_value got=%h exp=ffffff80", rdata);
      end
      run_access(1'b1, 2'b00, 1'b0, 32'h13, 32'h0, 32'h80FF1234, 1, 1'b0, "lbu");
      total++;
      if (rdata !== 32'h00000080) begin
         bad++; $display("FAIL lbu_value got=%h exp=00000080", rdata);
      end
      run_access(1'b0, 2'b01, 1'b0, 32'h22, 32'h0000ABCD, 32'h0, 0, 1'b1, "sh_0x22");
      run_access(1'b1, 2'b10, 1'b0, 32'h06, 32'h0, 32'h0, 0, 1'b1, "lw_misaligned");
      run_access(1'b1, 2'b11, 1'b0, 32'h08, 32'h0, 32'h0, 0, 1'b0, "size_illegal");
      run_access(1'b1, 2'b01, 1'b1, 32'h2E, 32'h0, 32'h8001_7FFF, 0, 1'b0, "lh_upper");
      run_access(1'b1, 2'b10, 1'b0, 32'h40, 32'h0, 32'h1234_5678, -1, 1'b0, "lw_timeout");
      run_access(1'b0, 2'b10, 1'b0, 32'h44, 32'hCAFE_F00D, 32'h0, -1, 1'b1, "sw_timeout");
   endtask

   task automatic test_reset_mid_access();
      bit quiet = 1;
      @(negedge clk);
      mem_en = 1'b1; mem_rw = 1'b1; mem_size = 2'b10; mem_sign = 1'b0;
      mem_addr = 32'h80; ram_bus.ram_ack = 1'b0;
      @(negedge clk); mem_en = 1'b0;       // 1st ACCESS cycle
      @(negedge clk); #1;                  // 2nd ACCESS cycle
      total++;
      if (ram_bus.ram_req !== 1'b1) begin
         bad++; $display("FAIL midreset_in_access got=req%b exp=req1", ram_bus.ram_req);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      ram_bus.ram_ack = 1'b1; ram_bus.ram_rdata = 32'h5555AAAA;
      #1;
      total++;
      if (ram_bus.ram_req !== 1'b0 || stall !== 1'b0) begin
         bad++;
         $display("FAIL midreset_req_dropped got=req%b stall%b exp=req0 stall0",
                  ram_bus.ram_req, stall);
      end
      model_rdata = '0;
      for (int i = 0; i < 4; i++) begin
         if (ram_bus.ram_req || stall || rdata_valid || align_err || bus_err || rdata !== '0)
            quiet = 0;
         @(negedge clk); ram_bus.ram_ack = 1'b0; #1;
      end
      total++;
      if (!quiet) begin
         bad++; $display("FAIL midreset_no_pulses got=activity exp=none");
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 150; n++) begin
         logic [1:0]  size = 2'($urandom_range(0, 3));
         logic [31:0] addr = $urandom;
         int          r    = $urandom_range(0, 9);
         int          nb   = m_nb(size);
         if (nb != 0 && $urandom_range(0, 3) != 0) addr = addr & ~32'(nb - 1);
         run_access(1'($urandom), size, 1'($urandom), addr, $urandom, $urandom,
                    (r == 9) ? -1 : (r % 4), 1'($urandom), $sformatf("rand%0d", n));
      end
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 4; n++)
         run_access(1'b1, 2'b00, 1'b1, 32'h100 + 32'(n), 32'h0, 32'h7F80_FF01, 0, 1'b1,
                    $sformatf("b2b%0d", n));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=no_finish exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_idle_ack();
      test_directed();
      test_back_to_back();
      test_reset_mid_access();
      test_random();
      test_idle_ack();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
